// File: rtl/gcd_pkg.sv
// Shared constants for the GCD scheduler: state encoding and default sizes.
package gcd_pkg;

  localparam int GCD_N_REQ = 4;
  localparam int GCD_WIDTH = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LAUNCH   = 2'd1;
  localparam logic [1:0] ST_WAIT_RES = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester strictly after
// the pointer, wrapping around. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx
);

  logic found;

  // Scan ptr+1, ptr+2, ... ptr+N_REQ (mod N_REQ); the pointer itself comes last.
  always_comb begin : pick
    int cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one subtractive GCD engine among N_REQ requesters. Grants are
// round-robin; operand pairs containing zero are answered directly because
// the engine never terminates on them.
module gcd_scheduler
  import gcd_pkg::*;
#(
  parameter int N_REQ = GCD_N_REQ,
  parameter int WIDTH = GCD_WIDTH,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       result,
  output logic [IDW-1:0]         result_id,
  output logic                   busy,
  output logic                   eng_go,
  output logic [WIDTH-1:0]       eng_a,
  output logic [WIDTH-1:0]       eng_b,
  input  logic                   eng_done,
  input  logic                   eng_out_en,
  input  logic [WIDTH-1:0]       eng_result
);

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [N_REQ-1:0] mask_q, mask_d;

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [N_REQ-1:0] id_onehot;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;

  // Unpack flat operand buses and decode the current id to one-hot.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign a_arr[gi]     = a_in[gi*WIDTH +: WIDTH];
    assign b_arr[gi]     = b_in[gi*WIDTH +: WIDTH];
    assign id_onehot[gi] = (id_q == IDW'(gi));
    assign ack[gi]       = (state_q == ST_RESP) && id_onehot[gi];
  end

  // The requester acked last cycle sits out one arbitration round.
  assign eligible = req & ~mask_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_a = a_arr[grant_idx];
  assign grant_b = b_arr[grant_idx];

  // Next-state logic: grant in IDLE, pulse go, wait for engine, acknowledge.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    mask_d   = (state_q == ST_RESP) ? id_onehot : '0;
    case (state_q)
      ST_IDLE: begin
        // Launching while the engine is busy would corrupt its run, so wait.
        if ((|grant) && eng_done) begin
          id_d  = grant_idx;
          ptr_d = grant_idx;
          a_d   = grant_a;
          b_d   = grant_b;
          if ((grant_a == '0) || (grant_b == '0)) begin
            result_d = grant_a | grant_b;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_RES;
      ST_WAIT_RES: begin
        if (eng_out_en) begin
          result_d = eng_result;
          state_d  = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; pointer resets to the last index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      ptr_q    <= IDW'(N_REQ - 1);
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      mask_q   <= mask_d;
    end
  end

  assign result    = result_q;
  assign result_id = id_q;
  assign busy      = (state_q != ST_IDLE);
  assign eng_go    = (state_q == ST_LAUNCH);
  assign eng_a     = a_q;
  assign eng_b     = b_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler with a behavioural subtractive GCD engine.
module tb_gcd_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] a_in = '0;
  logic [63:0] b_in = '0;
  logic [3:0]  ack;
  logic [15:0] result;
  logic [1:0]  result_id;
  logic        busy;
  logic        eng_go;
  logic [15:0] eng_a, eng_b;
  logic        eng_done;
  logic        eng_out_en;
  logic [15:0] eng_result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int go_cnt = 0;
  logic eng_hold = 1'b0;

  gcd_scheduler #(.N_REQ(4), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .result(result), .result_id(result_id), .busy(busy),
    .eng_go(eng_go), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_out_en(eng_out_en), .eng_result(eng_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (eng_go) go_cnt++;

  // Engine model: go sampled while idle, result strobe 4 cycles later plus
  // 3 cycles per subtract iteration; done and out_en high together at the end.
  function automatic int sub_iters(input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    logic [15:0] p = x, q = y;
    while (p != q && p != 0 && q != 0 && n < 1000) begin
      if (p > q) p = p - q; else q = q - p;
      n++;
    end
    return n;
  endfunction

  function automatic logic [15:0] sub_gcd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p = x, q = y;
    int n = 0;
    while (p != q && p != 0 && q != 0 && n < 1000) begin
      if (p > q) p = p - q; else q = q - p;
      n++;
    end
    return p;
  endfunction

  logic        eng_busy;
  int          eng_cnt;
  logic [15:0] eng_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_busy <= 1'b0; eng_cnt <= 0; eng_res <= '0;
    end else if (!eng_busy) begin
      if (eng_go) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 3 + 3 * sub_iters(eng_a, eng_b);
        eng_res  <= sub_gcd(eng_a, eng_b);
      end
    end else if (eng_cnt == 0) begin
      eng_busy <= 1'b0;
    end else begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  assign eng_out_en = eng_busy && (eng_cnt == 0);
  assign eng_done   = !eng_hold && (!eng_busy || eng_out_en);
  assign eng_result = eng_res;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) at falling edges for any ack; no comparison made here.
  task automatic wait_ack(input int maxc, output logic [3:0] a, output logic [15:0] r,
                          output logic [1:0] id, output int at, output bit to);
    to = 1'b1; a = '0; r = '0; id = '0; at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (|ack) begin
        a = ack; r = result; id = result_id; at = cyc; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic set_ops(input int k, input logic [15:0] a, input logic [15:0] b);
    a_in[k*16 +: 16] = a;
    b_in[k*16 +: 16] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (result !== 16'd0) begin errors++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++; if (result_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", result_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (eng_go !== 1'b0) begin errors++; $display("FAIL reset_go got=%b exp=0", eng_go); end
    checks++; if (eng_a !== 16'd0 || eng_b !== 16'd0) begin errors++; $display("FAIL reset_eng_ops got=%0d,%0d exp=0,0", eng_a, eng_b); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_equal_ops();
    logic [3:0] a; logic [15:0] r; logic [1:0] id; int at; bit to; int c;
    set_ops(0, 16'd12, 16'd12);
    req = 4'b0001; c = cyc;
    wait_ack(50, a, r, id, at, to);
    req = 4'b0000;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL eq_timeout got=timeout exp=ack"); end
    checks++; if (at !== c + 6) begin errors++; $display("FAIL eq_latency got=c+%0d exp=c+6", at - c); end
    checks++; if (a !== 4'b0001) begin errors++; $display("FAIL eq_ack got=%b exp=0001", a); end
    checks++; if (r !== 16'd12) begin errors++; $display("FAIL eq_result got=%0d exp=12", r); end
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL eq_id got=%0d exp=0", id); end
    @(negedge clk);
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL eq_ack_one_cycle got=%b exp=0000", ack); end
    $display("equal_ops: req0 12,12 ack=%b result=%0d id=%0d latency=%0d", a, r, id, at - c);
  endtask

  task automatic test_48_18();
    logic [3:0] a; logic [15:0] r; logic [1:0] id; int at; bit to; int c; int g0;
    set_ops(1, 16'd48, 16'd18);
    g0 = go_cnt;
    req = 4'b0010; c = cyc;
    wait_ack(80, a, r, id, at, to);
    req = 4'b0000;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL g48_timeout got=timeout exp=ack"); end
    checks++; if (a !== 4'b0010) begin errors++; $display("FAIL g48_ack got=%b exp=0010", a); end
    checks++; if (r !== 16'd6) begin errors++; $display("FAIL g48_result got=%0d exp=6", r); end
    checks++; if (at !== c + 18) begin errors++; $display("FAIL g48_latency got=c+%0d exp=c+18", at - c); end
    checks++; if (go_cnt - g0 !== 1) begin errors++; $display("FAIL g48_go_count got=%0d exp=1", go_cnt - g0); end
    repeat (3) @(negedge clk);
    checks++; if (ack !== 4'b0 || go_cnt - g0 !== 1) begin errors++; $display("FAIL g48_single_ack got ack=%b go=%0d exp 0000,1", ack, go_cnt - g0); end
    $display("gcd_48_18: ack=%b result=%0d latency=%0d go=%0d", a, r, at - c, go_cnt - g0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] a; logic [15:0] r; logic [1:0] id; int at; bit to; int prev;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) set_ops(k, 16'd9, 16'd6);
    req = 4'b1111;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(60, a, r, id, at, to);
      req[id] = 1'b0;
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout[%0d] got=timeout exp=ack", k); end
      checks++; if (id !== 2'(k)) begin errors++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", k, id, k); end
      checks++; if (a !== 4'(1 << k)) begin errors++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", k, a, 4'(1 << k)); end
      checks++; if (r !== 16'd3) begin errors++; $display("FAIL b2b_result[%0d] got=%0d exp=3", k, r); end
      if (k > 0) begin
        checks++; if (at - prev !== 13) begin errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=13", k, at - prev); end
      end
      $display("back_to_back: ack=%b id=%0d result=%0d", a, id, r);
      prev = at;
    end
    req = 4'b0000;
  endtask

  task automatic test_zero_bypass();
    logic [3:0] a; logic [15:0] r; logic [1:0] id; int at; bit to; int c; int g0;
    set_ops(2, 16'd0, 16'd7);
    g0 = go_cnt;
    @(negedge clk);
    req = 4'b0100; c = cyc;
    wait_ack(10, a, r, id, at, to);
    req = 4'b0000;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL zero_timeout got=timeout exp=ack"); end
    checks++; if (at !== c + 1) begin errors++; $display("FAIL zero_latency got=c+%0d exp=c+1", at - c); end
    checks++; if (a !== 4'b0100) begin errors++; $display("FAIL zero_ack got=%b exp=0100", a); end
    checks++; if (r !== 16'd7) begin errors++; $display("FAIL zero_result got=%0d exp=7", r); end
    $display("zero_bypass: 0,7 ack=%b result=%0d latency=%0d", a, r, at - c);
    repeat (2) @(negedge clk);
    checks++; if (result !== 16'd7) begin errors++; $display("FAIL result_hold got=%0d exp=7", result); end
    set_ops(2, 16'd0, 16'd0);
    req = 4'b0100; c = cyc;
    wait_ack(10, a, r, id, at, to);
    req = 4'b0000;
    checks++; if (to !== 1'b0 || r !== 16'd0 || at !== c + 1) begin errors++; $display("FAIL zero_zero got result=%0d latency=%0d exp 0,1", r, at - c); end
    checks++; if (go_cnt !== g0) begin errors++; $display("FAIL zero_no_go got=%0d exp=%0d", go_cnt, g0); end
    $display("zero_bypass: 0,0 result=%0d", r);
  endtask

  task automatic test_reset_mid();
    logic [3:0] a; logic [15:0] r; logic [1:0] id; int at; bit to; int c;
    @(negedge clk);
    set_ops(3, 16'd48, 16'd18);
    req = 4'b1000;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || ack !== 4'b0 || eng_go !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl got busy=%b ack=%b go=%b exp 0,0000,0", busy, ack, eng_go); end
    checks++; if (eng_a !== 16'd0 || eng_b !== 16'd0 || result !== 16'd0 || result_id !== 2'd0) begin errors++; $display("FAIL mid_reset_data got a=%0d b=%0d r=%0d id=%0d exp zeros", eng_a, eng_b, result, result_id); end
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    wait_ack(25, a, r, id, at, to);
    checks++; if (to !== 1'b1) begin errors++; $display("FAIL mid_no_ack got=%b exp=no ack", a); end
    set_ops(1, 16'd12, 16'd8);
    req = 4'b0010; c = cyc;
    wait_ack(60, a, r, id, at, to);
    req = 4'b0000;
    checks++; if (to !== 1'b0 || a !== 4'b0010 || id !== 2'd1) begin errors++; $display("FAIL mid_after_ack got ack=%b id=%0d exp 0010,1", a, id); end
    checks++; if (r !== 16'd4) begin errors++; $display("FAIL mid_after_result got=%0d exp=4", r); end
    checks++; if (at !== c + 12) begin errors++; $display("FAIL mid_after_latency got=c+%0d exp=c+12", at - c); end
    $display("reset_mid: after release ack=%b result=%0d", a, r);
  endtask

  task automatic test_alternate();
    logic [3:0] a; logic [15:0] r; logic [1:0] id; int at; bit to; int g0; int held_go;
    logic [1:0]  exp_id [4];
    logic [15:0] exp_r  [4];
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd0; exp_id[3] = 2'd1;
    exp_r[0] = 16'd10; exp_r[1] = 16'd7; exp_r[2] = 16'd10; exp_r[3] = 16'd7;
    @(negedge clk);
    set_ops(0, 16'd10, 16'd10);
    set_ops(1, 16'd14, 16'd21);
    eng_hold = 1'b1;
    g0 = go_cnt;
    req = 4'b0011;
    held_go = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (eng_go || busy) held_go++;
    end
    checks++; if (held_go !== 0) begin errors++; $display("FAIL hold_off got=%0d active cycles exp=0", held_go); end
    checks++; if (go_cnt !== g0) begin errors++; $display("FAIL hold_off_go got=%0d exp=%0d", go_cnt, g0); end
    eng_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(60, a, r, id, at, to);
      checks++; if (to !== 1'b0 || id !== exp_id[k]) begin errors++; $display("FAIL alt_order[%0d] got=%0d exp=%0d", k, id, exp_id[k]); end
      checks++; if (r !== exp_r[k]) begin errors++; $display("FAIL alt_result[%0d] got=%0d exp=%0d", k, r, exp_r[k]); end
      $display("alternate: ack=%b id=%0d result=%0d", a, id, r);
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_equal_ops();
    test_48_18();
    test_back_to_back();
    test_zero_bypass();
    test_reset_mid();
    test_alternate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Shares one GCD engine (controller plus datapath) among `N_REQ` requesters. It arbitrates pending requests round-robin, loads the winner's operands into the engine, and pulses `go`. It then captures the engine result and returns it to the winner with a one-cycle `ack`. Operand pairs containing zero bypass the engine, since the subtractive engine never terminates on them.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 16, operand/result width
- `IDW`, $clog2(N_REQ), requester index width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `req`  in  N_REQ  per-requester request level, held with operands until `ack`
- `a_in`  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `b_in`  in  N_REQ*WIDTH  operand B, same packing
- `ack`  out  N_REQ  one-hot, one-cycle result strobe
- `result`  out  WIDTH  GCD, valid while any `ack` bit is high
- `result_id`  out  IDW  index of the acked requester
- `busy`  out  1  high in every state except IDLE
- `eng_go`  out  1  start pulse to engine
- `eng_a`, `eng_b`  out  WIDTH  registered operands to engine
- `eng_done`  in  1  engine idle/finished level
- `eng_out_en`  in  1  engine single-cycle result-valid strobe
- `eng_result`  in  WIDTH  engine result

## Operation
- Reset values:
  - outputs: `ack`=0, `result`=0, `result_id`=0, `busy`=0, `eng_go`=0, `eng_a`=`eng_b`=0
  - internal: state=IDLE, RR pointer=N_REQ-1 (requester 0 highest priority first)
- IDLE:
  - Eligible set = `req` & ~`mask`. `mask` is the one-hot of the requester acked in the previous cycle and is cleared after one cycle.
  - If the eligible set is non-zero and `eng_done`=1:
    - grant the first eligible index after the pointer (wrapping);
    - register id, A, B; set the pointer to id.
  - If A=0 or B=0: `result` = A|B (gcd(0,0)=0), go to RESP. Otherwise go to LAUNCH.
  - If `eng_done`=0, stay in IDLE; no grant.
- LAUNCH: `eng_go`=1 for exactly this cycle; `eng_a`/`eng_b` hold the captured operands. Go to WAIT_RES.
- WAIT_RES:
  - `eng_a`/`eng_b` stay stable.
  - On `eng_out_en`=1, register `eng_result` into `result` and go to RESP.
  - `eng_done` is ignored here.
- RESP: `ack[id]`=1, `result` and `result_id` valid; set `mask`; go to IDLE.
- Operands are captured only at grant. Input changes or `req` drop after the grant do not affect the transaction; `ack` is still issued.
- Non-granted requesters keep waiting; there is no timeout.
- `result` holds its value between transactions.

## Timing
- Engine contract:
  - `go` is sampled while the engine is idle; the operand load follows one cycle later.
  - `eng_out_en` and `eng_done` are high together in the final cycle.
- Grant decided in cycle c (IDLE). LAUNCH at c+1.
- For a==b, `eng_out_en` arrives at c+5 and `ack` at c+6. Each subtract iteration adds 3 cycles.
- Zero bypass: `ack` at c+1.
- Back-to-back throughput: the next grant is possible in the cycle after RESP. The just-acked requester is excluded for that cycle.
- Reset mid-operation: all state returns to IDLE asynchronously and no `ack` is issued. The engine shares `rst`. After reset, no launch happens until `eng_done`=1.

## Structure
- `gcd_pkg`: state encoding (IDLE, LAUNCH, WAIT_RES, RESP), default `WIDTH`/`N_REQ` constants.
- Sub-module `rr_arbiter`: combinational round-robin pick from (eligible vector, pointer) → one-hot grant plus index. The pointer register lives in `gcd_scheduler`.

## Test plan
- Single request, req0 with A=12, B=12 → `ack[0]` at c+6, `result`=12, `result_id`=0.
- req1 with A=48, B=18 → `ack[1]` once, `result`=6; `eng_go` pulses exactly once.
- req0–req3 asserted simultaneously, all with A=9, B=6, each dropping `req` after its `ack` → acks in order 0,1,2,3, each `result`=3.
- Zero bypass:
  - req2 with A=0, B=7 → `ack[2]` at c+1, `result`=7, `eng_go` never high;
  - A=0, B=0 → `result`=0.
- `rst` asserted during WAIT_RES → outputs at reset values immediately, no `ack`; a new request after release completes correctly.
- Hold req0 high continuously alongside req1 → grants alternate 0,1,0,1; `eng_go` is held off while `eng_done`=0.
